// File: rtl/addsub_seq16_pkg.sv
// Shared types and constants for the nibble-serial add/sub unit.
// Holds the FSM encoding and the counter width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_seq16_nibble_add4.sv
// Single 4-bit adder slice reused over every nibble.
// Purely combinational.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/addsub_seq16.sv
// Nibble-serial add/subtract, LSB nibble first, carry kept in a register.
// Valid/ready request in, valid/ready response out.
module addsub_seq16
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_c,
  output logic             rsp_zero,
  output logic             rsp_ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = cnt_w(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             zero_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       sum;
  logic             cout;
  logic             sum_nz;

  nibble_add4 u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (sum),
    .cout (cout)
  );

  assign sum_nz = |sum;
  assign rsp_s  = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b ^ {WIDTH{req_sub}};
            carry_q   <= req_sub;
            cnt_q     <= '0;
            zero_q    <= 1'b1;
            req_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          res_q   <= {sum, res_q[WIDTH-1:NIBBLE_W]};
          carry_q <= cout;
          zero_q  <= zero_q & ~sum_nz;
          cnt_q   <= cnt_q + 1'b1;
          // On the last slice a_q/b_q hold the operand top nibbles
          if (cnt_q == LAST) begin
            rsp_c     <= cout;
            rsp_zero  <= zero_q & ~sum_nz;
            rsp_ovf   <= (a_q[3] == b_q[3]) &&
                         (sum[3] != a_q[3]);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
